// File: rtl/i2c_regfile_ctrl.sv
// rtl/i2c_regfile_ctrl.sv - I2C register-file controller with CDC event sync and local port arbitration
// I2C events come from a toggle/level SCL-domain peripheral; the local port yields to them.
module i2c_regfile_ctrl #(
   parameter int                  NUM_REGS = 16,
   parameter int                  ADDR_W   = 4,
   parameter logic [NUM_REGS-1:0] RO_MASK  = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_tgl,
   input  logic                  tx_tgl,
   input  logic                  txn_active,
   output logic [7:0]            tx_data,
   input  logic                  loc_req,
   input  logic                  loc_we,
   input  logic [ADDR_W-1:0]     loc_addr,
   input  logic [7:0]            loc_wdata,
   output logic                  loc_gnt,
   output logic [7:0]            loc_rdata,
   output logic [NUM_REGS*8-1:0] cfg_bus,
   output logic                  wr_pulse,
   output logic [ADDR_W-1:0]     wr_addr
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PTR   = 2'd1,
      ST_WRITE = 2'd2,
      ST_READ  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [7:0]          regs_q [NUM_REGS];
   logic [7:0]          regs_d [NUM_REGS];
   logic [7:0]          tx_data_q, tx_data_d;
   logic [7:0]          loc_rdata_q, loc_rdata_d;
   logic                loc_gnt_q, loc_gnt_d;
   logic                wr_pulse_q, wr_pulse_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [2:0]          rx_sync_q, rx_sync_d;
   logic [2:0]          tx_sync_q, tx_sync_d;
   logic [2:0]          txn_sync_q, txn_sync_d;

   logic rx_ev, tx_ev, txn_rise, txn_fall;

   // Bits [1:0] are the two-flop synchronizer, bit 2 holds the previous synced value.
   assign rx_sync_d  = {rx_sync_q[1:0], rx_tgl};
   assign tx_sync_d  = {tx_sync_q[1:0], tx_tgl};
   assign txn_sync_d = {txn_sync_q[1:0], txn_active};

   assign rx_ev    = rx_sync_q[1] ^ rx_sync_q[2];
   assign tx_ev    = tx_sync_q[1] ^ tx_sync_q[2];
   assign txn_rise = txn_sync_q[1] & ~txn_sync_q[2];
   assign txn_fall = ~txn_sync_q[1] & txn_sync_q[2];

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      regs_d      = regs_q;
      wr_pulse_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      loc_gnt_d   = 1'b0;
      loc_rdata_d = loc_rdata_q;
      tx_data_d   = regs_q[ptr_q];

      case (state_q)
         ST_IDLE: begin
            if (txn_rise) state_d = ST_PTR;
         end
         ST_PTR, ST_READ: begin
            if (rx_ev) begin
               ptr_d   = rx_data[ADDR_W-1:0];
               state_d = ST_WRITE;
            end else if (tx_ev) begin
               ptr_d   = ptr_q + 1'b1;
               state_d = ST_READ;
            end
         end
         ST_WRITE: begin
            if (rx_ev) begin
               if (!RO_MASK[ptr_q]) begin
                  regs_d[ptr_q] = rx_data;
                  wr_pulse_d    = 1'b1;
                  wr_addr_d     = ptr_q;
               end
               ptr_d = ptr_q + 1'b1;
            end else if (tx_ev) begin
               ptr_d   = ptr_q + 1'b1;
               state_d = ST_READ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A STOP coinciding with a byte still lets the byte land above.
      if (txn_fall) state_d = ST_IDLE;

      if (loc_req && !(rx_ev || tx_ev)) begin
         loc_gnt_d = 1'b1;
         if (loc_we) regs_d[loc_addr] = loc_wdata;
         else        loc_rdata_d      = regs_q[loc_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
         tx_data_q   <= 8'h00;
         loc_rdata_q <= 8'h00;
         loc_gnt_q   <= 1'b0;
         wr_pulse_q  <= 1'b0;
         wr_addr_q   <= '0;
         rx_sync_q   <= 3'b000;
         tx_sync_q   <= 3'b000;
         txn_sync_q  <= 3'b000;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         regs_q      <= regs_d;
         tx_data_q   <= tx_data_d;
         loc_rdata_q <= loc_rdata_d;
         loc_gnt_q   <= loc_gnt_d;
         wr_pulse_q  <= wr_pulse_d;
         wr_addr_q   <= wr_addr_d;
         rx_sync_q   <= rx_sync_d;
         tx_sync_q   <= tx_sync_d;
         txn_sync_q  <= txn_sync_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign loc_rdata = loc_rdata_q;
   assign loc_gnt   = loc_gnt_q;
   assign wr_pulse  = wr_pulse_q;
   assign wr_addr   = wr_addr_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
      assign cfg_bus[8*g +: 8] = regs_q[g];
   end

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
// tb/tb_i2c_regfile_ctrl.sv - directed self-checking bench for i2c_regfile_ctrl
// Register 2 is read-only from I2C in this instance.
module tb_i2c_regfile_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   rx_data;
   logic         rx_tgl;
   logic         tx_tgl;
   logic         txn_active;
   logic [7:0]   tx_data;
   logic         loc_req;
   logic         loc_we;
   logic [3:0]   loc_addr;
   logic [7:0]   loc_wdata;
   logic         loc_gnt;
   logic [7:0]   loc_rdata;
   logic [127:0] cfg_bus;
   logic         wr_pulse;
   logic [3:0]   wr_addr;

   int total = 0;
   int bad   = 0;
   int wp_cnt = 0;
   logic [3:0] wp_last1 = 4'h0;
   logic [3:0] wp_last2 = 4'h0;

   i2c_regfile_ctrl #(.NUM_REGS(16), .ADDR_W(4), .RO_MASK(16'h0004)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_tgl(rx_tgl), .tx_tgl(tx_tgl),
      .txn_active(txn_active), .tx_data(tx_data), .loc_req(loc_req), .loc_we(loc_we),
      .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_gnt(loc_gnt), .loc_rdata(loc_rdata),
      .cfg_bus(cfg_bus), .wr_pulse(wr_pulse), .wr_addr(wr_addr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_pulse === 1'b1) begin
         wp_cnt++;
         wp_last2 = wp_last1;
         wp_last1 = wr_addr;
      end
   end

   task automatic wait_clks(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_tgl  = ~rx_tgl;
      wait_clks(6);
   endtask

   task automatic txn_start();
      txn_active = 1'b1;
      wait_clks(5);
   endtask

   task automatic txn_stop();
      txn_active = 1'b0;
      wait_clks(5);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(2);
      total++; if (cfg_bus !== 128'h0) begin bad++; $display("FAIL reset_cfg got=%h exp=0", cfg_bus); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      total++; if (loc_gnt !== 1'b0 || wr_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", loc_gnt, wr_pulse); end
      total++; if (dut.ptr_q !== 4'h0 || wr_addr !== 4'h0) begin bad++; $display("FAIL reset_ptr got=%h/%h exp=0/0", dut.ptr_q, wr_addr); end
   endtask

   task automatic test_write_seq();
      int c0;
      c0 = wp_cnt;
      txn_start();
      send_byte(8'h03);
      send_byte(8'hAA);
      send_byte(8'h55);
      txn_stop();
      total++; if (cfg_bus[31:24] !== 8'hAA) begin bad++; $display("FAIL wr_reg3 got=%h exp=aa", cfg_bus[31:24]); end
      total++; if (cfg_bus[39:32] !== 8'h55) begin bad++; $display("FAIL wr_reg4 got=%h exp=55", cfg_bus[39:32]); end
      total++; if (dut.ptr_q !== 4'h5) begin bad++; $display("FAIL wr_ptr got=%h exp=5", dut.ptr_q); end
      total++; if (wp_cnt - c0 != 2) begin bad++; $display("FAIL wr_pulse_cnt got=%0d exp=2", wp_cnt - c0); end
      total++; if (wp_last2 !== 4'h3 || wp_last1 !== 4'h4) begin bad++; $display("FAIL wr_addr_seq got=%h,%h exp=3,4", wp_last2, wp_last1); end
      total++; if (dut.state_q !== 2'd0) begin bad++; $display("FAIL wr_state got=%0d exp=0", dut.state_q); end
   endtask

   task automatic test_wrap();
      txn_start();
      send_byte(8'h0F);
      send_byte(8'h11);
      send_byte(8'h22);
      txn_stop();
      total++; if (cfg_bus[127:120] !== 8'h11) begin bad++; $display("FAIL wrap_reg15 got=%h exp=11", cfg_bus[127:120]); end
      total++; if (cfg_bus[7:0] !== 8'h22) begin bad++; $display("FAIL wrap_reg0 got=%h exp=22", cfg_bus[7:0]); end
      total++; if (dut.ptr_q !== 4'h1) begin bad++; $display("FAIL wrap_ptr got=%h exp=1", dut.ptr_q); end
   endtask

   task automatic test_read();
      txn_start();
      send_byte(8'hF5);
      send_byte(8'h5A);
      send_byte(8'hA5);
      txn_stop();
      txn_start();
      send_byte(8'h05);
      txn_stop();
      txn_start();
      total++; if (tx_data !== 8'h5A) begin bad++; $display("FAIL rd_first got=%h exp=5a", tx_data); end
      tx_tgl = ~tx_tgl;
      wait_clks(4);
      total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL rd_second got=%h exp=a5", tx_data); end
      tx_tgl = ~tx_tgl;
      wait_clks(6);
      total++; if (dut.ptr_q !== 4'h7) begin bad++; $display("FAIL rd_ptr got=%h exp=7", dut.ptr_q); end
      txn_stop();
   endtask

   task automatic test_ro_mask();
      int c0, lat;
      c0 = wp_cnt;
      txn_start();
      send_byte(8'h02);
      send_byte(8'h77);
      txn_stop();
      total++; if (cfg_bus[23:16] !== 8'h00) begin bad++; $display("FAIL ro_reg2 got=%h exp=00", cfg_bus[23:16]); end
      total++; if (wp_cnt != c0) begin bad++; $display("FAIL ro_pulse got=%0d exp=%0d", wp_cnt, c0); end
      total++; if (dut.ptr_q !== 4'h3) begin bad++; $display("FAIL ro_ptr got=%h exp=3", dut.ptr_q); end
      loc_we = 1'b1; loc_addr = 4'h2; loc_wdata = 8'h77; loc_req = 1'b1;
      lat = 0;
      for (int i = 1; i <= 5 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (loc_gnt === 1'b1) lat = i;
      end
      loc_req = 1'b0;
      wait_clks(1);
      total++; if (lat != 1) begin bad++; $display("FAIL loc_wr_latency got=%0d exp=1", lat); end
      total++; if (cfg_bus[23:16] !== 8'h77) begin bad++; $display("FAIL loc_wr_reg2 got=%h exp=77", cfg_bus[23:16]); end
      total++; if (dut.ptr_q !== 4'h3) begin bad++; $display("FAIL loc_wr_ptr got=%h exp=3", dut.ptr_q); end
   endtask

   task automatic test_arbitration();
      int c0, lat;
      logic [7:0] rd;
      txn_start();
      send_byte(8'h03);
      c0 = wp_cnt;
      rx_data = 8'h3C;
      rx_tgl  = ~rx_tgl;
      wait_clks(2);
      loc_we = 1'b0; loc_addr = 4'h3; loc_req = 1'b1;
      lat = 0; rd = 8'h00;
      for (int i = 1; i <= 5 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (loc_gnt === 1'b1) begin lat = i; rd = loc_rdata; end
      end
      loc_req = 1'b0;
      wait_clks(3);
      total++; if (lat != 2) begin bad++; $display("FAIL arb_latency got=%0d exp=2", lat); end
      total++; if (rd !== 8'h3C) begin bad++; $display("FAIL arb_rdata got=%h exp=3c", rd); end
      total++; if (wp_cnt - c0 != 1) begin bad++; $display("FAIL arb_wr_pulse got=%0d exp=1", wp_cnt - c0); end
      txn_stop();
      loc_addr = 4'h4; loc_req = 1'b1;
      lat = 0; rd = 8'h00;
      for (int i = 1; i <= 5 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (loc_gnt === 1'b1) begin lat = i; rd = loc_rdata; end
      end
      loc_req = 1'b0;
      wait_clks(1);
      total++; if (lat != 1 || rd !== 8'h55) begin bad++; $display("FAIL loc_rd_reg4 got=%0d/%h exp=1/55", lat, rd); end
   endtask

   task automatic test_mid_reset();
      int c0;
      txn_start();
      send_byte(8'h09);
      txn_active = 1'b0;
      rst_n = 1'b0;
      wait_clks(1);
      rst_n = 1'b1;
      wait_clks(1);
      total++; if (cfg_bus !== 128'h0) begin bad++; $display("FAIL mrst_cfg got=%h exp=0", cfg_bus); end
      total++; if (dut.ptr_q !== 4'h0) begin bad++; $display("FAIL mrst_ptr got=%h exp=0", dut.ptr_q); end
      c0 = wp_cnt;
      send_byte(8'h44);
      send_byte(8'h66);
      total++; if (cfg_bus !== 128'h0 || wp_cnt != c0) begin bad++; $display("FAIL mrst_ignored got=%h/%0d exp=0/%0d", cfg_bus, wp_cnt, c0); end
      txn_start();
      send_byte(8'h01);
      send_byte(8'h99);
      txn_stop();
      total++; if (cfg_bus[15:8] !== 8'h99) begin bad++; $display("FAIL mrst_resume got=%h exp=99", cfg_bus[15:8]); end
   endtask

   initial begin
      rst_n = 1'b0; rx_data = 8'h00; rx_tgl = 1'b0; tx_tgl = 1'b0; txn_active = 1'b0;
      loc_req = 1'b0; loc_we = 1'b0; loc_addr = 4'h0; loc_wdata = 8'h00;
      test_reset();
      test_write_seq();
      test_wrap();
      test_read();
      test_ro_mask();
      test_arbitration();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_regfile_ctrl.md
Name: i2c_regfile_ctrl

Overview:
Clock-domain controller behind the SCL-clocked I2C peripheral. It turns received bytes into a register-pointer plus register-write sequence and supplies the byte the peripheral shifts out on reads. It also arbitrates a local system-side port against I2C traffic for the same register file. The register file drives configuration into the rest of the FPGA.

Parameters:
NUM_REGS, 16, number of 8-bit registers; must be a power of two.
ADDR_W, 4, pointer width; equals log2(NUM_REGS).
RO_MASK, 16'h0000, bit i = 1 makes register i read-only from I2C. The local port can still write it.

Ports:
clk  in  1  system clock; the only clock.
rst_n  in  1  synchronous, active-low reset.
rx_data  in  8  last received I2C byte; stable for at least 4 clk after each rx_tgl toggle.
rx_tgl  in  1  asynchronous; toggles once per received write byte.
tx_tgl  in  1  asynchronous; toggles once per transmitted read byte that the controller ACKed.
txn_active  in  1  asynchronous; high from START to STOP.
tx_data  out  8  byte the peripheral transmits next; equals regs[ptr].
loc_req  in  1  local access request; held until loc_gnt.
loc_we  in  1  1 = write, 0 = read; sampled with loc_req.
loc_addr  in  ADDR_W  local register address.
loc_wdata  in  8  local write data.
loc_gnt  out  1  one-cycle grant pulse.
loc_rdata  out  8  read data; valid in the loc_gnt cycle.
cfg_bus  out  NUM_REGS*8  all registers flattened; reg i occupies bits [8i+7:8i].
wr_pulse  out  1  one-cycle pulse on any I2C register write.
wr_addr  out  ADDR_W  address of the last I2C write.

Behaviour:
- Reset (rst_n low at a clk edge):
  - regs, ptr, tx_data, loc_rdata, wr_addr all 0.
  - loc_gnt and wr_pulse 0; state IDLE.
  - Synchronizer flops cleared to 0.
- CDC:
  - rx_tgl, tx_tgl and txn_active each pass through a 2-FF synchronizer, then a third flop for edge detection.
  - rx_ev = any edge of synced rx_tgl; tx_ev = any edge of synced tx_tgl.
  - txn_rise and txn_fall come from synced txn_active.
  - Event latency is 3 clk from the input change to the action.
  - rx_data is sampled in the rx_ev cycle without synchronization; its stability window guarantees a clean sample.
- State machine:
  - IDLE: txn_rise -> PTR.
  - PTR: rx_ev -> ptr <= rx_data[ADDR_W-1:0], upper bits ignored; go to WRITE. tx_ev -> ptr <= ptr+1; go to READ.
  - WRITE: rx_ev -> regs[ptr] <= rx_data unless RO_MASK[ptr]. wr_pulse=1 and wr_addr=ptr only when the write happens. ptr <= ptr+1 in all cases. tx_ev -> ptr+1; go to READ.
  - READ: tx_ev -> ptr <= ptr+1. rx_ev -> treated as a new pointer byte: ptr <= rx_data; go to WRITE.
  - Any state: txn_fall -> IDLE. ptr is retained across transactions so a bare read continues from the last pointer.
  - txn_rise and txn_fall in the same cycle cannot occur (single synced signal).
  - txn_fall in the same cycle as rx_ev: the byte is processed first, then the state is IDLE.
- Pointer: increments wrap modulo NUM_REGS (ptr = NUM_REGS-1 -> 0).
- tx_data: registered regs[ptr] each cycle, 1 clk behind ptr or register changes.
  - Updated by the clk after tx_ev, well before the peripheral's next byte (8 SCL periods).
- Local port arbitration:
  - I2C events have priority.
  - A loc_req in a cycle with rx_ev or tx_ev is deferred; otherwise loc_gnt=1 that cycle.
  - Write: regs[loc_addr] <= loc_wdata, RO_MASK ignored.
  - Read: loc_rdata <= regs[loc_addr], registered, valid together with loc_gnt on the following edge.
  - Grant latency: 1 clk from request if no conflict, else 2.
  - After loc_gnt the requester deasserts loc_req or issues a new request; back-to-back grants are allowed.
  - Local writes do not move ptr and do not assert wr_pulse.
- Reset mid-transaction: everything returns to reset values. A later rx_ev while in IDLE is ignored until the next txn_rise.
- rx_ev in IDLE: ignored.

Test Plan:
1. Reset, START, bytes 0x03, 0xAA, 0x55, STOP -> regs[3]=0xAA, regs[4]=0x55, ptr=5; two wr_pulse with wr_addr 3 then 4; state IDLE.
2. START, 0x0F, 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22 (wrap); ptr=1.
3. With regs[5]=0x5A, regs[6]=0xA5: START, ptr byte 0x05, STOP, START, two tx_tgl toggles -> tx_data 0x5A, then 0xA5 within 4 clk of the first toggle; ptr=7.
4. RO_MASK=16'h0004: I2C write 0x77 to reg 2 -> regs[2] unchanged, no wr_pulse, ptr=3. Local write 0x77 to reg 2 -> regs[2]=0x77.
5. loc_req read of addr 3 raised so that it lands in the same cycle as a synced rx_ev -> I2C write applied first; loc_gnt one cycle later; loc_rdata reflects the post-write value.
6. rst_n low for 1 clk after a pointer byte mid-transaction -> cfg_bus=0, ptr=0; further rx_tgl toggles ignored until a new txn_active rise.
